// File: rtl/vm2002_change_dispenser_if.sv
// Handshake, payout and restock signals between the vend controller/supplier
// side and the vm2002 change dispenser.
interface vm2002_change_dispenser_if;
    // Payout request and result
    logic        bal_valid;
    logic [15:0] balance;
    logic        ready;
    logic [1:0]  coin_out;
    logic        coin_strobe;
    logic        done;
    logic        short;
    logic [15:0] short_amount;
    // Supplier restock port and inventory view
    logic        restock_valid;
    logic [1:0]  restock_coin;
    logic [3:0]  restock_count;
    logic        restock_err;
    logic [4:0]  nickel_cnt;
    logic [4:0]  dime_cnt;
    logic [4:0]  quarter_cnt;

    modport master (
        output bal_valid, balance, restock_valid, restock_coin, restock_count,
        input  ready, coin_out, coin_strobe, done, short, short_amount,
        input  restock_err, nickel_cnt, dime_cnt, quarter_cnt
    );

    modport slave (
        input  bal_valid, balance, restock_valid, restock_coin, restock_count,
        output ready, coin_out, coin_strobe, done, short, short_amount,
        output restock_err, nickel_cnt, dime_cnt, quarter_cnt
    );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// vm2002 change dispenser: pays a cent balance out as single coins, greedy
// largest-first against a restockable inventory, and reports any shortfall.
// Coin codes: 1 nickel (5), 2 dime (10), 3 quarter (25).
module vm2002_change_dispenser #(
    parameter int COIN_CAP  = 16,
    parameter int PULSE_GAP = 2
) (
    input  logic                          clk,
    input  logic                          hrst,
    input  logic                          srst,
    vm2002_change_dispenser_if.slave      bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_EMIT   = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    // GAP counts down from GAP_LOAD to zero, so it lasts PULSE_GAP-1 cycles.
    localparam logic [7:0] GAP_LOAD = (PULSE_GAP > 32'sd2) ? 8'(PULSE_GAP - 32'sd2) : 8'd0;
    localparam logic       SKIP_GAP = (PULSE_GAP <= 32'sd1) ? 1'b1 : 1'b0;
    localparam logic [5:0] CAP_6    = 6'(COIN_CAP);

    logic [2:0]  state_r;
    logic [15:0] rem_r;
    logic [7:0]  gap_r;
    logic [1:0]  coin_out_r;
    logic        coin_strobe_r;
    logic        done_r;
    logic        short_r;
    logic [15:0] short_amount_r;
    logic        restock_err_r;
    logic        ready_r;
    logic [4:0]  inv_r [1:3];

    logic [2:0]  state_nx_s;
    logic [15:0] rem_nx_s;
    logic [7:0]  gap_nx_s;
    logic [1:0]  coin_out_nx_s;
    logic        strobe_nx_s;
    logic        done_nx_s;
    logic        short_nx_s;
    logic [15:0] short_amount_nx_s;
    logic        err_nx_s;
    logic [4:0]  inv_nx_s [1:3];
    logic        pick_now_s;

    logic [1:0]  pick_code_s;
    logic [15:0] pick_val_s;
    logic [4:0]  rs_cur_s;
    logic [5:0]  rs_sum_s;
    logic        rs_ok_s;

    // Greedy coin choice for the current remainder and inventory.
    always_comb begin
        pick_code_s = 2'd0;
        pick_val_s  = 16'd0;
        if (rem_r >= 16'd25 && inv_r[2'd3] != 5'd0) begin
            pick_code_s = 2'd3;
            pick_val_s  = 16'd25;
        end else if (rem_r >= 16'd10 && inv_r[2'd2] != 5'd0) begin
            pick_code_s = 2'd2;
            pick_val_s  = 16'd10;
        end else if (rem_r >= 16'd5 && inv_r[2'd1] != 5'd0) begin
            pick_code_s = 2'd1;
            pick_val_s  = 16'd5;
        end else begin
            pick_code_s = 2'd0;
            pick_val_s  = 16'd0;
        end
    end

    // Restock acceptance: only in IDLE, losing to bal_valid, never past capacity.
    always_comb begin
        rs_cur_s = (bus.restock_coin == 2'd0) ? 5'd0 : inv_r[bus.restock_coin];
        rs_sum_s = {1'b0, rs_cur_s} + {2'b00, bus.restock_count};
        rs_ok_s  = (state_r == ST_IDLE) && !bus.bal_valid &&
                   (bus.restock_coin != 2'd0) && (rs_sum_s <= CAP_6);
    end

    // Next-state and next-output computation for the payout FSM.
    // The coin decision after a GAP is taken in the last GAP cycle (or in EMIT
    // when there is no GAP) so strobes are exactly PULSE_GAP cycles apart;
    // SELECT as a separate state only occurs right after acceptance.
    always_comb begin
        state_nx_s        = state_r;
        rem_nx_s          = rem_r;
        gap_nx_s          = gap_r;
        coin_out_nx_s     = 2'd0;
        strobe_nx_s       = 1'b0;
        done_nx_s         = 1'b0;
        short_nx_s        = short_r;
        short_amount_nx_s = short_amount_r;
        err_nx_s          = bus.restock_valid && !rs_ok_s;
        inv_nx_s          = inv_r;
        pick_now_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.bal_valid) begin
                    rem_nx_s          = bus.balance;
                    short_nx_s        = 1'b0;
                    short_amount_nx_s = 16'd0;
                    state_nx_s        = ST_SELECT;
                end else if (bus.restock_valid && rs_ok_s) begin
                    inv_nx_s[bus.restock_coin] = rs_sum_s[4:0];
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SELECT: pick_now_s = 1'b1;
            ST_EMIT: begin
                if (SKIP_GAP) begin
                    pick_now_s = 1'b1;
                end else begin
                    state_nx_s = ST_GAP;
                    gap_nx_s   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_r == 8'd0) begin
                    pick_now_s = 1'b1;
                end else begin
                    gap_nx_s = gap_r - 8'd1;
                end
            end
            ST_FINISH: begin
                state_nx_s = ST_IDLE;
                rem_nx_s   = 16'd0;
            end
            default: begin
                state_nx_s = ST_IDLE;
                rem_nx_s   = 16'd0;
            end
        endcase

        // Decrement and strobe land on the same edge, so inventory always
        // reflects every coin that has been strobed out.
        case ({pick_now_s, (pick_code_s == 2'd0)})
            2'b11: begin
                state_nx_s        = ST_FINISH;
                done_nx_s         = 1'b1;
                short_nx_s        = (rem_r != 16'd0);
                short_amount_nx_s = rem_r;
            end
            2'b10: begin
                state_nx_s             = ST_EMIT;
                strobe_nx_s            = 1'b1;
                coin_out_nx_s          = pick_code_s;
                rem_nx_s               = rem_r - pick_val_s;
                inv_nx_s[pick_code_s]  = inv_r[pick_code_s] - 5'd1;
            end
            default: ;
        endcase
    end

    // State, output and inventory registers; soft reset aborts but keeps coins.
    always_ff @(posedge clk or posedge hrst) begin
        if (hrst) begin
            state_r        <= ST_IDLE;
            rem_r          <= 16'd0;
            gap_r          <= 8'd0;
            coin_out_r     <= 2'd0;
            coin_strobe_r  <= 1'b0;
            done_r         <= 1'b0;
            short_r        <= 1'b0;
            short_amount_r <= 16'd0;
            restock_err_r  <= 1'b0;
            ready_r        <= 1'b1;
            inv_r          <= '{default: 5'd0};
        end else if (srst) begin
            state_r        <= ST_IDLE;
            rem_r          <= 16'd0;
            gap_r          <= 8'd0;
            coin_out_r     <= 2'd0;
            coin_strobe_r  <= 1'b0;
            done_r         <= 1'b0;
            short_r        <= 1'b0;
            short_amount_r <= 16'd0;
            restock_err_r  <= 1'b0;
            ready_r        <= 1'b1;
        end else begin
            state_r        <= state_nx_s;
            rem_r          <= rem_nx_s;
            gap_r          <= gap_nx_s;
            coin_out_r     <= coin_out_nx_s;
            coin_strobe_r  <= strobe_nx_s;
            done_r         <= done_nx_s;
            short_r        <= short_nx_s;
            short_amount_r <= short_amount_nx_s;
            restock_err_r  <= err_nx_s;
            ready_r        <= (state_nx_s == ST_IDLE);
            inv_r          <= inv_nx_s;
        end
    end

    assign bus.ready        = ready_r;
    assign bus.coin_out     = coin_out_r;
    assign bus.coin_strobe  = coin_strobe_r;
    assign bus.done         = done_r;
    assign bus.short        = short_r;
    assign bus.short_amount = short_amount_r;
    assign bus.restock_err  = restock_err_r;
    assign bus.nickel_cnt   = inv_r[2'd1];
    assign bus.dime_cnt     = inv_r[2'd2];
    assign bus.quarter_cnt  = inv_r[2'd3];

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for vm2002_change_dispenser: directed scenarios followed by random
// restock/payout rounds, checked against a greedy inventory model.
module tb_vm2002_change_dispenser;

    logic clk = 1'b0;
    logic hrst;
    logic srst;

    always #5 clk = ~clk;

    vm2002_change_dispenser_if bus ();

    vm2002_change_dispenser #(.COIN_CAP(16), .PULSE_GAP(2)) dut (
        .clk  (clk),
        .hrst (hrst),
        .srst (srst),
        .bus  (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int inv_m [1:3];
    int exp_q [$];

    function automatic int coin_val(input int d);
        case (d)
            1: return 5;
            2: return 10;
            3: return 25;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inv(input string tag);
        check({tag, "_nickels"},  bus.nickel_cnt,  inv_m[1]);
        check({tag, "_dimes"},    bus.dime_cnt,    inv_m[2]);
        check({tag, "_quarters"}, bus.quarter_cnt, inv_m[3]);
    endtask

    task automatic restock(input int coin, input int count);
        bit exp_err;
        if (coin == 0) exp_err = 1'b1;
        else           exp_err = (inv_m[coin] + count > 16);
        @(negedge clk);
        bus.restock_valid = 1'b1;
        bus.restock_coin  = coin[1:0];
        bus.restock_count = count[3:0];
        @(negedge clk);
        bus.restock_valid = 1'b0;
        check("restock_err", bus.restock_err, exp_err);
        if (!exp_err) inv_m[coin] += count;
        check_inv("restock");
    endtask

    // Full payout: model the greedy result, then follow the DUT cycle by cycle.
    task automatic payout(input int bal);
        int  rem;
        int  n;
        int  k;
        bit  seen_done;
        rem = bal;
        exp_q.delete();
        for (int d = 3; d >= 1; d--) begin
            while (rem >= coin_val(d) && inv_m[d] > 0) begin
                exp_q.push_back(d);
                rem -= coin_val(d);
                inv_m[d]--;
            end
        end
        @(negedge clk);
        bus.bal_valid = 1'b1;
        bus.balance   = bal[15:0];
        @(negedge clk);
        bus.bal_valid = 1'b0;
        check("busy_not_ready", bus.ready, 1'b0);
        n = 0;
        seen_done = 1'b0;
        for (k = 1; k <= 300 && !seen_done; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.coin_strobe) begin
                if (n < exp_q.size()) check("coin_code", bus.coin_out, exp_q[n]);
                else                  check("coin_count_overrun", n + 1, exp_q.size());
                check("strobe_cycle", k, 2 + 2 * n);
                n++;
            end
            if (bus.done) begin
                seen_done = 1'b1;
                check("done_cycle", k, 2 + 2 * exp_q.size());
                check("short", bus.short, (rem != 0));
                check("short_amount", bus.short_amount, rem);
            end
        end
        check("done_seen", seen_done, 1'b1);
        check("coin_count", n, exp_q.size());
        check_inv("payout");
        @(negedge clk);
        check("ready_after", bus.ready, 1'b1);
    endtask

    initial begin
        int extra;
        hrst = 1'b1;
        srst = 1'b0;
        bus.bal_valid     = 1'b0;
        bus.balance       = 16'd0;
        bus.restock_valid = 1'b0;
        bus.restock_coin  = 2'd0;
        bus.restock_count = 4'd0;
        inv_m = '{0, 0, 0};

        // Reset state
        @(negedge clk);
        check("rst_ready", bus.ready, 1'b1);
        check("rst_coin_out", bus.coin_out, 2'd0);
        check("rst_strobe", bus.coin_strobe, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_short", bus.short, 1'b0);
        check("rst_short_amount", bus.short_amount, 16'd0);
        check("rst_restock_err", bus.restock_err, 1'b0);
        check_inv("rst");
        hrst = 1'b0;

        // T1: Q,Q,D,N for 65 cents
        restock(3, 4);
        restock(2, 2);
        restock(1, 2);
        payout(65);

        // T2: zero balance
        payout(0);

        // T6a: soft reset right after the first strobe
        restock(3, 2);
        restock(2, 1);
        restock(1, 1);
        @(negedge clk);
        bus.bal_valid = 1'b1;
        bus.balance   = 16'd65;
        @(negedge clk);
        bus.bal_valid = 1'b0;
        @(negedge clk);
        check("srst_first_strobe", bus.coin_strobe, 1'b1);
        check("srst_first_code", bus.coin_out, 2'd3);
        inv_m[3]--;
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check("srst_ready", bus.ready, 1'b1);
        check("srst_short_amount", bus.short_amount, 16'd0);
        check_inv("srst");
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.coin_strobe || bus.done) extra++;
            @(negedge clk);
        end
        check("srst_no_activity", extra, 0);

        // T6b: hard reset mid-payout
        @(negedge clk);
        bus.bal_valid = 1'b1;
        bus.balance   = 16'd65;
        @(negedge clk);
        bus.bal_valid = 1'b0;
        @(negedge clk);
        check("hrst_pre_strobe", bus.coin_strobe, 1'b1);
        hrst = 1'b1;
        #1;
        inv_m = '{0, 0, 0};
        check("hrst_strobe", bus.coin_strobe, 1'b0);
        check("hrst_coin_out", bus.coin_out, 2'd0);
        check("hrst_ready", bus.ready, 1'b1);
        check_inv("hrst");
        @(negedge clk);
        hrst = 1'b0;

        // T3: dime only, 20 cents short
        restock(2, 1);
        payout(30);

        // T4: nickel then 2 cents short
        restock(1, 2);
        payout(7);

        // T5: capacity limit and restock error cases
        restock(3, 2);
        restock(3, 15);
        restock(3, 14);
        restock(0, 3);
        restock(2, 0);

        // Restock losing to bal_valid, then restock while busy
        @(negedge clk);
        bus.bal_valid     = 1'b1;
        bus.balance       = 16'd0;
        bus.restock_valid = 1'b1;
        bus.restock_coin  = 2'd1;
        bus.restock_count = 4'd1;
        @(negedge clk);
        bus.bal_valid = 1'b0;
        check("restock_vs_bal_err", bus.restock_err, 1'b1);
        @(negedge clk);
        bus.restock_valid = 1'b0;
        check("restock_busy_err", bus.restock_err, 1'b1);
        check("restock_busy_done", bus.done, 1'b1);
        check_inv("restock_busy");
        @(negedge clk);

        // Random restock/payout rounds
        for (int it = 0; it < 20; it++) begin
            restock(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            restock(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            payout(int'($urandom_range(0, 150)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
